// File: rtl/fft_pkg.sv
// Shared constants, types and index helpers for the FFT output reorder buffer.
// The geometry is fixed here so the top and the banks agree on every width.
package fft_pkg;

    localparam int N     = 512;
    localparam int P     = 16;
    localparam int W     = 13;
    localparam int LOG2N = $clog2(N);
    localparam int LOG2P = $clog2(P);
    localparam int BEATS = N / P;
    localparam int BW    = $clog2(BEATS);

    typedef logic signed [W-1:0] sample_t;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL,
        DRAINING
    } bank_st_e;

    // Reverses the low nbits of idx; the upper bits of the result are zero.
    function automatic logic [LOG2N-1:0] bitrev(
        input logic [LOG2N-1:0] idx,
        input int               nbits
    );
        logic [LOG2N-1:0] v;
        logic [LOG2N-1:0] r;
        v = idx;
        r = '0;
        for (int i = 0; i < LOG2N; i++) begin
            if (i < nbits) begin
                r = (r << 1) | LOG2N'(v[0]);
                v = v >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One frame of sample storage: P-wide scatter write to bit-reversed
// addresses, P-wide contiguous read of one natural-order beat.
module fft_reorder_bank
    import fft_pkg::*;
(
    input  logic                clk,
    input  logic                we,
    input  logic [BW-1:0]       wr_beat,
    input  logic [P-1:0][W-1:0] wr_real,
    input  logic [P-1:0][W-1:0] wr_imag,
    input  logic [BW-1:0]       rd_beat,
    output logic [P-1:0][W-1:0] rd_real,
    output logic [P-1:0][W-1:0] rd_imag
);

    logic [2*W-1:0]             mem [N];
    logic [P-1:0][LOG2N-1:0]    wr_addr;

    always_comb begin
        for (int l = 0; l < P; l++) begin
            wr_addr[l] = bitrev({wr_beat, LOG2P'(l)}, LOG2N);
        end
    end

    // Storage is not reset: bank state in the top decides what is live.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int l = 0; l < P; l++) begin
                mem[wr_addr[l]] <= {wr_real[l], wr_imag[l]};
            end
        end
    end

    always_comb begin
        for (int j = 0; j < P; j++) begin
            {rd_real[j], rd_imag[j]} = mem[{rd_beat, LOG2P'(j)}];
        end
    end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: bit-reversed FFT beats in, natural-order beats
// out with ready/valid; one bank fills while the other drains.
module fft_bitrev_reorder
    import fft_pkg::*;
(
    input  logic                clk,
    input  logic                rstn,
    input  logic                valid_in,
    input  logic [P-1:0][W-1:0] in_real,
    input  logic [P-1:0][W-1:0] in_imag,
    output logic                valid_out,
    input  logic                out_ready,
    output logic [P-1:0][W-1:0] out_real,
    output logic [P-1:0][W-1:0] out_imag,
    output logic                out_last,
    output logic                overflow
);

    localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

    bank_st_e [1:0]             st_q;
    bank_st_e [1:0]             st_d;
    logic                       wsel;
    logic                       rsel;
    logic [BW-1:0]              wcnt;
    logic [BW-1:0]              rcnt;
    logic                       wr_ok;
    logic                       rd_ok;
    logic                       wr_en;
    logic                       rd_acc;
    logic                       wr_last;
    logic                       rd_last;
    logic [1:0]                 wr_hit;
    logic [1:0]                 rd_hit;
    logic [1:0][P-1:0][W-1:0]   rd_real;
    logic [1:0][P-1:0][W-1:0]   rd_imag;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int b = 0; b < 2; b++) begin
                st_q[b] <= EMPTY;
            end
        end else begin
            st_q <= st_d;
        end
    end

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            st_d[b] = st_q[b];
            unique case (st_q[b])
                EMPTY: begin
                    if (wr_hit[b]) st_d[b] = wr_last ? FULL : FILLING;
                end
                FILLING: begin
                    if (wr_hit[b] && wr_last) st_d[b] = FULL;
                end
                FULL: begin
                    if (rd_hit[b]) st_d[b] = rd_last ? EMPTY : DRAINING;
                end
                DRAINING: begin
                    if (rd_hit[b] && rd_last) st_d[b] = EMPTY;
                end
                default: st_d[b] = EMPTY;
            endcase
        end
    end

    always_comb begin
        wr_ok = (st_q[wsel] == EMPTY) || (st_q[wsel] == FILLING);
        rd_ok = (st_q[rsel] == FULL) || (st_q[rsel] == DRAINING);
    end

    assign wr_en   = valid_in & wr_ok;
    assign rd_acc  = rd_ok & out_ready;
    assign wr_last = wr_en && (wcnt == LAST);
    assign rd_last = rd_acc && (rcnt == LAST);
    assign wr_hit  = {wr_en & wsel, wr_en & ~wsel};
    assign rd_hit  = {rd_acc & rsel, rd_acc & ~rsel};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wsel     <= 1'b0;
            rsel     <= 1'b0;
            wcnt     <= '0;
            rcnt     <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wcnt <= wr_last ? '0 : wcnt + BW'(1);
                if (wr_last) wsel <= ~wsel;
            end
            if (rd_acc) begin
                rcnt <= rd_last ? '0 : rcnt + BW'(1);
                if (rd_last) rsel <= ~rsel;
            end
            if (valid_in && !wr_ok) overflow <= 1'b1;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_reorder_bank u_bank (
            .clk     (clk),
            .we      (wr_hit[b]),
            .wr_beat (wcnt),
            .wr_real (in_real),
            .wr_imag (in_imag),
            .rd_beat (rcnt),
            .rd_real (rd_real[b]),
            .rd_imag (rd_imag[b])
        );
    end

    // Read pointers only move on acceptance, so a stalled beat stays put.
    assign valid_out = rd_ok;
    assign out_last  = rd_ok && (rcnt == LAST);
    assign out_real  = rd_ok ? rd_real[rsel] : '0;
    assign out_imag  = rd_ok ? rd_imag[rsel] : '0;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Randomized bench for the reorder buffer against a frame-queue model.
// The model scatters each beat by bit reversal and drains whole frames.
module tb_fft_bitrev_reorder;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic                 valid_in;
    logic [15:0][12:0]    in_real;
    logic [15:0][12:0]    in_imag;
    logic                 valid_out;
    logic                 out_ready;
    logic [15:0][12:0]    out_real;
    logic [15:0][12:0]    out_imag;
    logic                 out_last;
    logic                 overflow;

    fft_bitrev_reorder dut (
        .clk       (clk),
        .rstn      (rstn),
        .valid_in  (valid_in),
        .in_real   (in_real),
        .in_imag   (in_imag),
        .valid_out (valid_out),
        .out_ready (out_ready),
        .out_real  (out_real),
        .out_imag  (out_imag),
        .out_last  (out_last),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: natural-order frames queued flat, 512 samples each.
    logic [12:0] mre[$];
    logic [12:0] mim[$];
    logic [12:0] pre[512];
    logic [12:0] pim[512];
    int  pcnt = 0;
    int  rbeat = 0;
    int  frames_in = 0;
    int  beats_out = 0;
    bit  ovf_m = 0;
    int  vin_pct, rdy_pct, mode;
    bit  ramp_on = 0;

    function automatic int bitrev9(int x);
        int r = 0;
        for (int i = 0; i < 9; i++) begin
            r = r * 2 + x % 2;
            x = x / 2;
        end
        return r;
    endfunction

    task automatic model_reset();
        mre.delete();
        mim.delete();
        pcnt = 0;
        rbeat = 0;
        ovf_m = 0;
    endtask

    task automatic step();
        logic [15:0][12:0] er, ei, rr, ri;
        bit ev, inacc, outacc;
        int v;
        @(negedge clk);
        ev = (mre.size() > 0);
        check("valid_out", valid_out, ev);
        check("overflow", overflow, ovf_m);
        check("out_last", out_last, ev && rbeat == 31);
        if (ev) begin
            for (int j = 0; j < 16; j++) begin
                er[j] = mre[rbeat * 16 + j];
                ei[j] = mim[rbeat * 16 + j];
                rr[j] = 13'(rbeat * 16 + j);
                ri[j] = 13'(-(rbeat * 16 + j));
            end
            check("out_real", out_real, er);
            check("out_imag", out_imag, ei);
            if (ramp_on) begin
                check("ramp_real", out_real, rr);
                check("ramp_imag", out_imag, ri);
            end
        end
        valid_in  = ($urandom_range(99) < vin_pct);
        out_ready = ($urandom_range(99) < rdy_pct);
        for (int l = 0; l < 16; l++) begin
            case (mode)
                0: begin
                    in_real[l] = 13'($urandom);
                    in_imag[l] = 13'($urandom);
                end
                1: begin
                    v = bitrev9(pcnt * 16 + l);
                    in_real[l] = 13'(v);
                    in_imag[l] = 13'(-v);
                end
                default: begin
                    in_real[l] = $urandom_range(1) ? 13'h0fff : 13'h1000;
                    in_imag[l] = $urandom_range(1) ? 13'h0fff : 13'h1000;
                end
            endcase
        end
        inacc  = valid_in && (pcnt > 0 || mre.size() < 1024);
        outacc = ev && out_ready;
        if (valid_in && !inacc) ovf_m = 1;
        if (outacc) begin
            beats_out++;
            rbeat++;
            if (rbeat == 32) begin
                rbeat = 0;
                repeat (512) begin
                    void'(mre.pop_front());
                    void'(mim.pop_front());
                end
            end
        end
        if (inacc) begin
            for (int l = 0; l < 16; l++) begin
                pre[bitrev9(pcnt * 16 + l)] = in_real[l];
                pim[bitrev9(pcnt * 16 + l)] = in_imag[l];
            end
            pcnt++;
            if (pcnt == 32) begin
                pcnt = 0;
                frames_in++;
                for (int k = 0; k < 512; k++) begin
                    mre.push_back(pre[k]);
                    mim.push_back(pim[k]);
                end
            end
        end
    endtask

    task automatic run(int n, int vp, int rp, int md);
        vin_pct = vp;
        rdy_pct = rp;
        mode = md;
        repeat (n) step();
    endtask

    task automatic check_zero(string tag);
        check({tag, "_valid"}, valid_out, 1'b0);
        check({tag, "_last"}, out_last, 1'b0);
        check({tag, "_ovf"}, overflow, 1'b0);
        check({tag, "_real"}, out_real, '0);
        check({tag, "_imag"}, out_imag, '0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, base;
        bit found;
        rstn = 1'b0;
        valid_in = 1'b0;
        out_ready = 1'b0;
        in_real = '0;
        in_imag = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rstn = 1'b1;

        ramp_on = 1;
        run(32, 100, 100, 1);
        run(40, 0, 100, 1);
        ramp_on = 0;

        b0 = beats_out;
        run(128, 100, 100, 0);
        run(40, 0, 100, 0);
        check("t2_beats", beats_out - b0, 128);
        check("t2_ovf", overflow, 1'b0);

        run(64, 100, 100, 2);
        run(40, 0, 100, 2);

        run(20, 100, 100, 0);
        run(70, 100, 0, 0);
        check("t3_ovf", overflow, 1'b1);
        run(100, 0, 100, 0);

        run(1500, 60, 50, 0);
        run(200, 0, 100, 0);

        base = frames_in;
        found = 0;
        vin_pct = 100;
        rdy_pct = 100;
        mode = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            step();
            if (frames_in > base && pcnt == 17) found = 1;
        end
        check("t5_reach", found, 1'b1);
        rstn = 1'b0;
        #1;
        check_zero("t5_rst");
        model_reset();
        valid_in = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        ramp_on = 1;
        run(32, 100, 100, 1);
        run(40, 0, 100, 1);
        ramp_on = 0;
        check("t5_idle", valid_out, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
